// File: rtl/nes_poller_if.sv
// nes_poller_if -- signal bundle between the NES poller and the controller
// side (shift register, request source, button consumer).
//
// Signals:
//   start    poll request into the poller
//   q        serial data from the shift register
//   srlatch  shift register parallel-load strobe
//   sr_en    shift register shift enable
//   busy     poller is not idle
//   buttons  last completed poll (N_BITS wide)
//   valid    one-cycle pulse when buttons updates
//   pressed  rising edges since the previous poll (only with NES_POLLER_EDGE_EN)
//
// Modports: master = poller side, slave = controller/consumer side.
// Optional macro: NES_POLLER_EDGE_EN adds the pressed bundle member.
interface nes_poller_if #(
   parameter int N_BITS = 8
);
   logic              start;
   logic              q;
   logic              srlatch;
   logic              sr_en;
   logic              busy;
   logic [N_BITS-1:0] buttons;
   logic              valid;
`ifdef NES_POLLER_EDGE_EN
   logic [N_BITS-1:0] pressed;

   modport master (
      input  start, q,
      output srlatch, sr_en, busy, buttons, valid, pressed
   );
   modport slave (
      output start, q,
      input  srlatch, sr_en, busy, buttons, valid, pressed
   );
`else
   modport master (
      input  start, q,
      output srlatch, sr_en, busy, buttons, valid
   );
   modport slave (
      output start, q,
      input  srlatch, sr_en, busy, buttons, valid
   );
`endif
endinterface

// File: rtl/nes_poller.sv
// nes_poller -- console-side sequencer for the NES controller shift register.
// On a start request it holds srlatch for LATCH_CYCLES clocks, then walks
// N_BITS bit slots of BIT_CYCLES clocks each, sampling q at the end of every
// slot (LSB = A first) and pulsing sr_en on that same edge except after the
// last bit. The assembled byte is registered into buttons with a one-cycle
// valid pulse. Single clock domain shared with the shift register.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    nes_poller_if.master: start, q in; srlatch, sr_en, busy,
//          buttons, valid (and pressed) out
//
// Parameters: N_BITS (>= 2), LATCH_CYCLES (>= 1), BIT_CYCLES (>= 1).
// Optional macro: NES_POLLER_EDGE_EN adds the registered pressed output
// (new_buttons & ~old_buttons), updated together with buttons.
module nes_poller #(
   parameter int N_BITS       = 8,
   parameter int LATCH_CYCLES = 2,
   parameter int BIT_CYCLES   = 4
) (
   input  logic         clk,
   input  logic         reset,
   nes_poller_if.master bus
);

   localparam int CNT_MAX = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_BITS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LATCH  = 2'd1,
      SAMPLE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [IW-1:0]     idx, idx_nxt;
   logic [N_BITS-1:0] shadow, shadow_nxt;
   logic [N_BITS-1:0] buttons;
   logic              valid;
   logic              slot_end;
   logic              done;

   // Last cycle of a bit slot: q is captured on the closing edge.
   assign slot_end = (state == SAMPLE) && (cnt == BIT_LAST);

   // Control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = LATCH;
               cnt_nxt   = '0;
            end
         end
         LATCH: begin
            if (cnt == LATCH_LAST) begin
               state_nxt = SAMPLE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         SAMPLE: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               if (idx == IDX_LAST) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Shadow assembly: the final bit is merged combinationally so buttons
   // can load the complete byte on the same edge that samples it.
   always_comb begin
      shadow_nxt = shadow;
      if (slot_end) begin
         shadow_nxt[idx] = bus.q;
      end
   end

   // Shadow is pure data; an aborted poll never reaches buttons, so it
   // needs no reset.
   always_ff @(posedge clk) begin
      shadow <= shadow_nxt;
   end

   // Result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buttons <= '0;
         valid   <= 1'b0;
      end else begin
         valid <= done;
         if (done) begin
            buttons <= shadow_nxt;
         end
      end
   end

`ifdef NES_POLLER_EDGE_EN
   logic [N_BITS-1:0] pressed;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pressed <= '0;
      end else if (done) begin
         pressed <= shadow_nxt & ~buttons;
      end
   end

   assign bus.pressed = pressed;
`endif

   // Outputs decoded from registered state only.
   assign bus.srlatch = (state == LATCH);
   assign bus.sr_en   = slot_end && (idx != IDX_LAST);
   assign bus.busy    = (state != IDLE);
   assign bus.buttons = buttons;
   assign bus.valid   = valid;

endmodule

// File: tb/tb_nes_poller.sv
// tb_nes_poller -- bench for nes_poller. Two instances: default parameters
// and LATCH_CYCLES=1/BIT_CYCLES=1. Each drives a behavioural controller
// shift register (load on srlatch, shift on sr_en, q = bit 0).
module tb_nes_poller;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   nes_poller_if #(.N_BITS(8)) bus_m ();
   nes_poller_if #(.N_BITS(8)) bus_s ();

   nes_poller #(.N_BITS(8), .LATCH_CYCLES(2), .BIT_CYCLES(4)) dut_m (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_m)
   );

   nes_poller #(.N_BITS(8), .LATCH_CYCLES(1), .BIT_CYCLES(1)) dut_s (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   // Controller shift-register models
   logic [7:0] btn_m = 8'h00;
   logic [7:0] btn_s = 8'h00;
   logic [7:0] sr_m  = 8'h00;
   logic [7:0] sr_s  = 8'h00;

   always @(posedge clk) begin
      if (bus_m.srlatch)    sr_m <= btn_m;
      else if (bus_m.sr_en) sr_m <= {1'b1, sr_m[7:1]};
      if (bus_s.srlatch)    sr_s <= btn_s;
      else if (bus_s.sr_en) sr_s <= {1'b1, sr_s[7:1]};
   end

   assign bus_m.q = sr_m[0];
   assign bus_s.q = sr_s[0];

   int errs   = 0;
   int checks = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (bus_m.busy && n < limit) begin
         step();
         n++;
      end
      chk1("idle_timeout", bus_m.busy, 1'b0);
   endtask

   // One full poll on the default instance, started in the current cycle
   // (cycle 0); returns in cycle 35 with the DUT in IDLE.
   task automatic run_poll(input logic [7:0] b, input logic [7:0] exp_b, input logic [7:0] exp_p);
      btn_m       = b;
      bus_m.start = 1'b1;
      step();
      bus_m.start = 1'b0;
      for (int c = 1; c <= 35; c++) begin
         chk1("poll_srlatch", bus_m.srlatch, c <= 2);
         chk1("poll_sr_en", bus_m.sr_en, (c >= 6) && (c <= 30) && ((c % 4) == 2));
         chk1("poll_busy", bus_m.busy, c < 35);
         chk1("poll_valid", bus_m.valid, c == 35);
         if (c == 35) begin
            chk8("poll_buttons", bus_m.buttons, exp_b);
`ifdef NES_POLLER_EDGE_EN
            chk8("poll_pressed", bus_m.pressed, exp_p);
`else
            if (exp_p !== exp_p) $display("unreachable");
`endif
         end
         if (c < 35) step();
      end
   endtask

   typedef struct {
      logic [7:0] btn;
      logic [7:0] exp_btn;
      logic [7:0] exp_pr;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int nvalid;
      int nlatch;

      vecs[0] = '{btn: 8'h09, exp_btn: 8'h09, exp_pr: 8'h09};
      vecs[1] = '{btn: 8'hFF, exp_btn: 8'hFF, exp_pr: 8'hF6};
      vecs[2] = '{btn: 8'h00, exp_btn: 8'h00, exp_pr: 8'h00};
      vecs[3] = '{btn: 8'h12, exp_btn: 8'h12, exp_pr: 8'h12};

      reset       = 1'b0;
      bus_m.start = 1'b0;
      bus_s.start = 1'b0;
      step();
      step();

      // Reset state
      chk1("rst_srlatch", bus_m.srlatch, 1'b0);
      chk1("rst_sr_en", bus_m.sr_en, 1'b0);
      chk1("rst_busy", bus_m.busy, 1'b0);
      chk1("rst_valid", bus_m.valid, 1'b0);
      chk8("rst_buttons", bus_m.buttons, 8'h00);
      chk8("rst_buttons_s", bus_s.buttons, 8'h00);
      chk1("rst_busy_s", bus_s.busy, 1'b0);
      reset = 1'b1;
      step();

      // Table-driven polls, issued back to back
      for (int i = 0; i < 4; i++) begin
         run_poll(vecs[i].btn, vecs[i].exp_btn, vecs[i].exp_pr);
      end

      // start held high: polls repeat every 35 cycles
      btn_m       = 8'h80;
      bus_m.start = 1'b1;
      nvalid      = 0;
      for (int c = 1; c <= 100; c++) begin
         step();
         if (bus_m.valid) nvalid++;
         chk1("hold_valid", bus_m.valid, (c == 35) || (c == 70));
         chk1("hold_srlatch", bus_m.srlatch,
              (c == 1) || (c == 2) || (c == 36) || (c == 37) || (c == 71) || (c == 72));
         if (c == 35 || c == 70) begin
            chk8("hold_buttons", bus_m.buttons, 8'h80);
`ifdef NES_POLLER_EDGE_EN
            chk8("hold_pressed", bus_m.pressed, (c == 35) ? 8'h80 : 8'h00);
`endif
         end
      end
      bus_m.start = 1'b0;
      chk_int("hold_valid_count", nvalid, 2);
      wait_idle(50);

      // start pulsed while busy is ignored
      btn_m       = 8'h01;
      bus_m.start = 1'b1;
      step();
      bus_m.start = 1'b0;
      nvalid      = 0;
      nlatch      = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus_m.valid) nvalid++;
         if (bus_m.srlatch) nlatch++;
         chk1("busy_start_valid", bus_m.valid, c == 35);
         if (c == 35) begin
            chk8("busy_start_buttons", bus_m.buttons, 8'h01);
`ifdef NES_POLLER_EDGE_EN
            chk8("busy_start_pressed", bus_m.pressed, 8'h01);
`endif
         end
         if (c == 10) bus_m.start = 1'b1;
         if (c == 11) bus_m.start = 1'b0;
         if (c < 40) step();
      end
      chk_int("busy_start_valid_count", nvalid, 1);
      chk_int("busy_start_latch_cycles", nlatch, 2);

      // Asynchronous reset mid-poll
      btn_m       = 8'h40;
      bus_m.start = 1'b1;
      step();
      bus_m.start = 1'b0;
      for (int c = 1; c < 20; c++) step();
      chk1("pre_reset_busy", bus_m.busy, 1'b1);
      reset = 1'b0;
      #1;
      chk1("arst_srlatch", bus_m.srlatch, 1'b0);
      chk1("arst_sr_en", bus_m.sr_en, 1'b0);
      chk1("arst_busy", bus_m.busy, 1'b0);
      chk1("arst_valid", bus_m.valid, 1'b0);
      chk8("arst_buttons", bus_m.buttons, 8'h00);
`ifdef NES_POLLER_EDGE_EN
      chk8("arst_pressed", bus_m.pressed, 8'h00);
`endif
      step();
      step();
      reset = 1'b1;
      nvalid = 0;
      for (int c = 23; c <= 40; c++) begin
         step();
         if (bus_m.valid) nvalid++;
         chk1("post_reset_busy", bus_m.busy, 1'b0);
      end
      chk_int("post_reset_valid_count", nvalid, 0);
      chk8("post_reset_buttons", bus_m.buttons, 8'h00);
      run_poll(8'h40, 8'h40, 8'h40);

      // LATCH_CYCLES=1, BIT_CYCLES=1 instance
      btn_s       = 8'h12;
      bus_s.start = 1'b1;
      step();
      bus_s.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         chk1("fast_srlatch", bus_s.srlatch, c == 1);
         chk1("fast_sr_en", bus_s.sr_en, (c >= 2) && (c <= 8));
         chk1("fast_busy", bus_s.busy, c < 10);
         chk1("fast_valid", bus_s.valid, c == 10);
         if (c == 10) begin
            chk8("fast_buttons", bus_s.buttons, 8'h12);
`ifdef NES_POLLER_EDGE_EN
            chk8("fast_pressed", bus_s.pressed, 8'h12);
`endif
         end
         if (c < 10) step();
      end
      step();
      chk1("fast_valid_drop", bus_s.valid, 1'b0);
      chk8("fast_buttons_hold", bus_s.buttons, 8'h12);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/nes_poller.md
Name: nes_poller

Overview:
Console-side sequencer for the NES controller shift register.
- On request, drives the parallel-load strobe (srlatch) to capture the 8 button inputs.
- Then pulses the shift enable once per bit and samples the serial output, LSB (A) first.
- Assembles the result into a registered button byte.
- Shares clk with the shift register, so the whole path is one clock domain, with no generated clock.

Parameters:
N_BITS, 8, number of serial bits per poll, and width of buttons.
LATCH_CYCLES, 2, clk cycles srlatch is held high; must be >= 1.
BIT_CYCLES, 4, clk cycles per bit slot; must be >= 1.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  poll request, sampled in IDLE only
q  input  1  serial data from the shift register sout
srlatch  output  1  shift register parallel-load strobe
sr_en  output  1  shift register shift enable, one-cycle pulses
busy  output  1  high in any state other than IDLE
buttons  output  N_BITS  last completed poll; bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right
valid  output  1  one-cycle pulse when buttons updates

Behaviour:
Reset (reset=0, asynchronous):
- State goes to IDLE.
- srlatch=0, sr_en=0, busy=0, buttons=0, valid=0; bit index and counters cleared.
- Reset asserted mid-poll aborts the poll with no partial update of buttons.

States: IDLE, LATCH, SAMPLE.
- IDLE: start=1 -> LATCH. Otherwise stay. start is ignored in all other states.
- LATCH: srlatch=1 for exactly LATCH_CYCLES cycles, then -> SAMPLE with idx=0, cnt=0. sr_en=0 throughout.
- SAMPLE: cnt counts 0..BIT_CYCLES-1. On the cnt==BIT_CYCLES-1 cycle:
  - Capture q into shadow[idx].
  - If idx < N_BITS-1: sr_en=1 for that single cycle, so the shift register advances on the same edge the sample is taken; idx++; cnt=0.
  - If idx == N_BITS-1: sr_en stays 0 (no shift after the last bit); buttons <= shadow with the final bit; valid=1 next cycle; -> IDLE.
- sr_en is 0 on all other cycles.

Outputs:
- srlatch, sr_en and busy are decoded from the registered state and counters. There is no combinational path from start or q to any output.

Timing (start sampled high at the end of cycle 0):
- LATCH occupies cycles 1..LATCH_CYCLES.
- Bit i is sampled at the end of cycle LATCH_CYCLES + (i+1)*BIT_CYCLES.
- buttons and valid change in cycle T = LATCH_CYCLES + N_BITS*BIT_CYCLES + 1. With defaults, T = 35.
- busy is high for cycles 1..T-1 and low in T.

Boundary cases:
- Back-to-back polls: the valid cycle is in IDLE, so start=1 in cycle T begins a new LATCH in cycle T+1.
- BIT_CYCLES=1: sr_en is high for N_BITS-1 consecutive cycles, then low.
- start held high continuously: polls repeat with a period of T cycles; valid pulses once per poll.
- buttons holds its value between polls; it is never cleared except by reset.

Optional Feature:
Macro NES_POLLER_EDGE_EN.
- Defined: adds output port `pressed` (N_BITS). It is registered and updated in the same cycle as buttons, equal to new_buttons & ~old_buttons (rising edges since the previous poll). It holds the value until the next valid, and resets to 0.
- Undefined: no `pressed` port, no extra registers; all other behaviour is identical.

Test Plan:
- Defaults, NES_Controller model on srlatch/sr_en/q, A=1 and Start=1, pulse start in cycle 0 -> srlatch high in cycles 1-2; 7 sr_en pulses at cycles 6,10,...,30; buttons=8'h09 and valid=1 in cycle 35 only.
- All buttons pressed, then all released, two polls -> buttons 8'hFF, then 8'h00. With NES_POLLER_EDGE_EN: pressed 8'hFF, then 8'h00.
- start held high for 100 cycles with Right=1 -> valid at cycles 35, 70; buttons=8'h80; srlatch re-asserted at cycles 36-37.
- start pulsed again at cycle 10 (busy) -> ignored: single valid at cycle 35, no extra srlatch.
- reset driven low at cycle 20, released at cycle 22, Left=1 -> srlatch/sr_en/busy drop to 0 asynchronously; buttons=0, no valid. A fresh start then yields buttons=8'h40.
- BIT_CYCLES=1, LATCH_CYCLES=1, Up=1 and B=1 -> sr_en high in cycles 2-8; buttons=8'h12 with valid in cycle 10.
